mem_fill_arbiter: RTL
=====================

Name: mem_fill_arbiter

Overview:
- Shares the single main-memory read port (fixed MEM_LATENCY-cycle pipelined read, one beat per cycle) between the I-cache and D-cache fill controllers.
- Grants whole-fill ownership to one Cache_Control instance by driving its proceed input.
- While a fill is in progress, muxes the owner's mem_en and address onto memory and routes memory_data_valid back to the owner only.
- Sits between both cache fill FSMs and the memory model, at the top of the memory subsystem.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- MEM_LATENCY, 4, cycles from mem_en to memory_data_valid; sizes the in-flight counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- i_req  in  1  I-cache miss_detected.
- i_busy  in  1  I-cache fsm_busy.
- i_mem_en  in  1  I-cache read enable.
- i_addr  in  ADDR_W  I-cache main_memory_address.
- i_proceed  out  1  grant to I-cache (its proceed input).
- i_data_valid  out  1  memory_data_valid routed to I-cache.
- d_req, d_busy, d_mem_en, d_addr, d_proceed, d_data_valid: same as the i_ ports, for the D-cache.
- mem_en  out  1  read enable to memory.
- mem_addr  out  ADDR_W  read address to memory.
- mem_data_valid  in  1  valid beat returning from memory.
- mem_data  in  DATA_W  returning data.
- fill_data  out  DATA_W  mem_data broadcast to both caches, combinational pass-through.
- owner  out  2  00 none, 01 I, 10 D; owner of the current or draining fill.
- err  out  1  sticky protocol error.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, DRAIN. Reset (rst_n=0 at posedge) forces:
  - state=IDLE, owner=00, last_grant=I, inflight=0, busy_seen=0, err=0.
  - Every output low, mem_addr=0.
- IDLE:
  - Only one request high: next state is that requester's GRANT.
  - Both high: grant the requester not equal to last_grant. After reset, D wins the first tie.
  - Grant is registered: proceed rises one cycle after req is sampled high.
  - Neither high: stay in IDLE.
- GRANT_x:
  - x_proceed=1 and owner=x.
  - mem_en=x_mem_en and mem_addr=x_addr, combinationally.
  - The other requester's mem_en and addr are ignored. Its proceed stays 0, and it keeps waiting with req high.
  - busy_seen is set the first cycle x_busy=1.
  - Release condition: (busy_seen & ~x_busy) or (~busy_seen & ~x_req), the latter being a spurious or cancelled request.
  - On release: last_grant=x, busy_seen cleared, proceed drops the next cycle.
  - Next state after release: IDLE if inflight==0 after this cycle's update, else DRAIN.
- DRAIN:
  - mem_en=0; owner holds the previous owner.
  - Go to IDLE when inflight reaches 0.
  - A new grant is not issued until IDLE.
- Valid routing:
  - x_data_valid = mem_data_valid & (owner==x), in GRANT and DRAIN states.
  - mem_data_valid with owner==00 sets err and is dropped.
- inflight counter (clog2(MEM_LATENCY+1) bits):
  - +1 when mem_en=1, -1 when mem_data_valid=1, unchanged when both occur.
  - Saturates at MEM_LATENCY and at 0.
  - An attempted overflow or underflow sets err.
- err clears only on reset.
- Arbitration is non-preemptive: a second request never affects an active fill. Back-to-back fills are separated by at least one IDLE cycle.
- Reset mid-fill: outputs drop in the same cycle as the reset edge, and in-flight returns after reset are ignored. They set err only if they arrive with rst_n=1 and owner==00.

Test Plan:
- Single I miss at addr 0x0006, 8-beat fill, latency 4:
  - i_proceed high from cycle after i_req until the cycle after i_busy falls.
  - Exactly 8 i_data_valid pulses, 0 d_data_valid pulses.
  - mem_addr equals i_addr on every mem_en cycle; err=0.
- i_req and d_req rise in the same cycle after reset:
  - D granted first.
  - I granted only after D releases and inflight==0, with one IDLE cycle between.
  - Next simultaneous tie goes to D again, since last_grant=I.
- D fill in progress while i_req is held high:
  - i_proceed=0 throughout; I-side mem_en toggles never reach mem_en.
  - I granted after D completes.
- Owner releases with 3 beats in flight:
  - State goes to DRAIN, owner holds 10.
  - 3 further d_data_valid pulses; IDLE after the last.
  - A pending i_req is granted the next cycle.
- Spurious request: d_req high for 1 cycle, d_busy never rises:
  - d_proceed pulses for 1 cycle, then IDLE; inflight=0; err=0.
- Error and reset cases:
  - mem_data_valid injected in IDLE: err=1 and stays 1.
  - rst_n low mid-fill: all outputs 0, owner=00, err=0 on the next cycle.

Source files
------------

// File: rtl/mem_fill_arbiter_if.sv
// Signal bundle between the fill arbiter, both cache fill FSMs and the memory read port.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_fill_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) ();
    // I-cache fill controller
    logic              i_req;
    logic              i_busy;
    logic              i_mem_en;
    logic [ADDR_W-1:0] i_addr;
    logic              i_proceed;
    logic              i_data_valid;
    // D-cache fill controller
    logic              d_req;
    logic              d_busy;
    logic              d_mem_en;
    logic [ADDR_W-1:0] d_addr;
    logic              d_proceed;
    logic              d_data_valid;
    // Memory read port
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_data;
    // Shared fill data and status
    logic [DATA_W-1:0] fill_data;
    logic [1:0]        owner;
    logic              err;

    modport slave (
        input  i_req, i_busy, i_mem_en, i_addr,
        input  d_req, d_busy, d_mem_en, d_addr,
        input  mem_data_valid, mem_data,
        output i_proceed, i_data_valid, d_proceed, d_data_valid,
        output mem_en, mem_addr, fill_data, owner, err
    );

    modport master (
        output i_req, i_busy, i_mem_en, i_addr,
        output d_req, d_busy, d_mem_en, d_addr,
        output mem_data_valid, mem_data,
        input  i_proceed, i_data_valid, d_proceed, d_data_valid,
        input  mem_en, mem_addr, fill_data, owner, err
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single pipelined main-memory read port between the I-cache and D-cache
// fill controllers. Ownership is granted for a whole fill; after the owner lets go, any
// beats still in flight drain back to it before a new grant can be issued.
module mem_fill_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_LATENCY = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_fill_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_LATENCY);

    localparam logic [1:0] OwnNone = 2'b00;
    localparam logic [1:0] OwnI    = 2'b01;
    localparam logic [1:0] OwnD    = 2'b10;

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDrain} state_e;

    state_e            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_grant_q, last_grant_d;  // 0: I, 1: D
    logic [CntW-1:0]   inflight_q, inflight_d;
    logic              busy_seen_q, busy_seen_d;
    logic              err_q, err_d;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] fill_data;
    logic              own_req;
    logic              own_busy;
    logic              release_fill;

    // Read-port mux: only the granted cache reaches memory, nothing while draining or idle.
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        case (state_q)
            StGrantI: begin
                mem_en   = bus.i_mem_en;
                mem_addr = bus.i_addr;
            end
            StGrantD: begin
                mem_en   = bus.d_mem_en;
                mem_addr = bus.d_addr;
            end
            default: ;
        endcase
    end

    // In-flight beat counter with saturation; any protocol violation makes err sticky.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (bus.mem_data_valid && (owner_q == OwnNone)) begin
            err_d = 1'b1;
        end
        if (mem_en && !bus.mem_data_valid) begin
            if (inflight_q == CntMax) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q + CntW'(1);
            end
        end else if (!mem_en && bus.mem_data_valid) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - CntW'(1);
            end
        end
    end

    // Grant FSM next state: round-robin tie break in idle, non-preemptive hold while granted.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        busy_seen_d  = busy_seen_q;
        own_req      = (state_q == StGrantD) ? bus.d_req  : bus.i_req;
        own_busy     = (state_q == StGrantD) ? bus.d_busy : bus.i_busy;
        // Before busy is ever seen, a dropped request means the miss was cancelled.
        release_fill = busy_seen_q ? !own_busy : (!own_busy && !own_req);

        case (state_q)
            StIdle: begin
                if (bus.d_req && (!bus.i_req || !last_grant_q)) begin
                    state_d = StGrantD;
                    owner_d = OwnD;
                end else if (bus.i_req) begin
                    state_d = StGrantI;
                    owner_d = OwnI;
                end
            end
            StGrantI, StGrantD: begin
                if (release_fill) begin
                    last_grant_d = (state_q == StGrantD);
                    busy_seen_d  = 1'b0;
                    if (inflight_d == '0) begin
                        state_d = StIdle;
                        owner_d = OwnNone;
                    end else begin
                        state_d = StDrain;
                    end
                end else begin
                    busy_seen_d = busy_seen_q | own_busy;
                end
            end
            StDrain: begin
                if (inflight_d == '0) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            last_grant_q <= 1'b0;
            inflight_q   <= '0;
            busy_seen_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            busy_seen_q  <= busy_seen_d;
            err_q        <= err_d;
        end
    end

    assign fill_data = bus.mem_data;

    // Output drive: grants from state, returning beats steered to the current owner only.
    always_comb begin
        bus.i_proceed    = (state_q == StGrantI);
        bus.d_proceed    = (state_q == StGrantD);
        bus.i_data_valid = bus.mem_data_valid && (owner_q == OwnI);
        bus.d_data_valid = bus.mem_data_valid && (owner_q == OwnD);
        bus.mem_en       = mem_en;
        bus.mem_addr     = mem_addr;
        bus.fill_data    = fill_data;
        bus.owner        = owner_q;
        bus.err          = err_q;
    end

endmodule
